a2d_rr_reader: RTL and testbench
================================

// Module: a2d_rr_reader
// PURPOSE
//  SPI initiator that reads the 12-bit ADC128S A2D converter for the Segway.
//  On each nxt request it converts the next channel of a fixed round-robin set
//  (left load cell, right load cell, battery) and updates that channel's
//  result register. Sits between the ADC128S SPI pins and the balance/steer logic.
//  Each conversion is two back-to-back 16-bit SPI transactions; the ADC returns
//  the channel selected by the previous transaction.
// PARAMETERS
//  LFT_CH   3'd0  A2D channel for left load cell
//  RGHT_CH  3'd4  A2D channel for right load cell
//  BATT_CH  3'd5  A2D channel for battery voltage
// PORTS
//  clk      in   1   system clock; single clock domain
//  rst_n    in   1   asynchronous active-low reset
//  nxt      in   1   pulse: start conversion of next round-robin channel
//  MISO     in   1   serial data from ADC
//  SS_n     out  1   active-low slave select
//  SCLK     out  1   serial clock = clk/32, idles high
//  MOSI     out  1   serial data to ADC, MSB first
//  lft_ld   out  12  latest LFT_CH result
//  rght_ld  out  12  latest RGHT_CH result
//  batt     out  12  latest BATT_CH result
//  upd      out  1   one-clk pulse when a result register is written
//  busy     out  1   high from accepted nxt until upd
// BEHAVIOUR
//  Reset: SS_n=1, SCLK=1, MOSI=0, lft_ld/rght_ld/batt=12'h000, upd=0, busy=0,
//   rr pointer=0 (LFT). Reset mid-transaction aborts at once; no partial write.
//  Round robin: ptr 0->1->2->0 (LFT,RGHT,BATT); advances in the upd cycle only.
//  Command word: {2'b00, ch[2:0], 11'h000}; same word sent in both transactions.
//  SPI transaction (sub-module): 5-bit div counter loaded 5'b10111 on start,
//   SS_n low same cycle; SCLK=div[4]. MISO sampled into shift reg when
//   div==5'b01111; shift reg shifts (MOSI=shft[15]) when div==5'b11111.
//   After 16th sample, at next div==5'b11111: no shift, SS_n=1, SCLK=1, done
//   pulses 1 clk, rd_data=shft. Transaction = 8+16*32 = 520 clks start->done.
//  FSM: IDLE --nxt--> TX1 (start) --done--> GAP (1 clk, SS_n high)
//   --> TX2 (start) --done--> UPD --> IDLE.
//   UPD: write rd_data[11:0] to register selected by ptr, upd=1, advance ptr.
//  nxt while busy: ignored (not queued). nxt in UPD cycle ignored.
//  nxt held high: new conversion starts the cycle after UPD.
//  SS_n never low in IDLE/GAP/UPD; SS_n deasserts >=1 clk between transactions.
//  Only rd_data[11:0] used; bits [15:12] discarded.
//  Non-target registers hold value during a conversion.
// STRUCTURE
//  Package a2d_pkg: state enum {IDLE,TX1,GAP,TX2,UPD}, rr ptr enum
//   {RR_LFT,RR_RGHT,RR_BATT}, SCLK divider load/sample/shift constants.
//  Sub-module spi_mstr16: generic 16-bit mode-3 SPI master (start, cmd[15:0],
//   done, rd_data[15:0], SS_n, SCLK, MOSI, MISO). Top holds FSM, ptr, results.
// TESTING (bench connects ADC128S behavioural model: lft=12'h3A5,
//  rght=12'h5C2, batt=12'hC34 set-points)
//  reset -> all outputs at reset values, SCLK=1, SS_n=1, no SCLK toggle w/o nxt
//  one nxt -> two SS_n low windows of 16 SCLK each, MOSI=16'h0000 both; upd at
//   ~1042 clks; lft_ld=12'h3A5, rght_ld/batt unchanged at 0
//  three nxt (each after upd) -> lft_ld=3A5, rght_ld=5C2 (MOSI 16'h2000),
//   batt=C34 (MOSI 16'h2800); fourth nxt wraps to LFT
//  nxt pulsed repeatedly during busy -> exactly one upd, ptr advances by 1
//  rst_n low mid-TX2 -> SS_n=1 same cycle, results stay 0, ptr=LFT after release
//  SCLK check: period 32 clks, MISO sampled on rise, MOSI stable across rise

Source files
------------

// File: rtl/a2d_pkg.sv
// Shared types and SCLK divider constants for the ADC128S round-robin reader.
package a2d_pkg;

    typedef enum logic [2:0] {IDLE, TX1, GAP, TX2, UPD} state_t;

    typedef enum logic [1:0] {RR_LFT, RR_RGHT, RR_BATT} rr_ptr_t;

    // SCLK = div[4]: loading 5'b10111 gives an 8-clk front porch with SCLK high.
    localparam logic [4:0] DIV_LOAD = 5'b10111;
    localparam logic [4:0] DIV_SMPL = 5'b01111;
    localparam logic [4:0] DIV_SHFT = 5'b11111;

    localparam logic [4:0] NUM_BITS = 5'd16;

    function automatic rr_ptr_t rr_next(input rr_ptr_t p);
        case (p)
            RR_LFT:  rr_next = RR_RGHT;
            RR_RGHT: rr_next = RR_BATT;
            default: rr_next = RR_LFT;
        endcase
    endfunction

endpackage

// File: rtl/a2d_rr_reader_if.sv
// SPI pin bundle between the reader (master) and the ADC128S (slave).
interface a2d_rr_reader_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/spi_mstr16.sv
// Generic 16-bit mode-3 SPI master: SCLK = clk/32, sample on SCLK rise,
// shift on SCLK fall, one-clk done pulse with the received word.
module spi_mstr16
    import a2d_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] rd_data,
    a2d_rr_reader_if.master spi
);

    logic        active_q, active_d;
    logic [4:0]  div_q,    div_d;
    logic [15:0] shft_q,   shft_d;
    logic        smpl_q,   smpl_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic        done_q,   done_d;

    // NOTE: every *_d gets a default before the ifs so no path leaves it unassigned (no latch).
    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        shft_d   = shft_q;
        smpl_d   = smpl_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        if (active_q) begin
            div_d = div_q + 5'd1;
            if (div_q == DIV_SMPL) begin
                smpl_d = spi.MISO;
                cnt_d  = cnt_q + 5'd1;
            end
            // The front-porch 11111 (no sample yet) must not shift out cmd[15].
            if (div_q == DIV_SHFT && cnt_q != 5'd0) begin
                shft_d = {shft_q[14:0], smpl_q};
            end
            if (div_q == DIV_SHFT && cnt_q == NUM_BITS) begin
                active_d = 1'b0;
                done_d   = 1'b1;
                div_d    = DIV_SHFT;
            end
        end else if (start) begin
            active_d = 1'b1;
            div_d    = DIV_LOAD;
            shft_d   = cmd;
            cnt_d    = 5'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            div_q    <= DIV_SHFT;
            shft_q   <= '0;
            smpl_q   <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            shft_q   <= shft_d;
            smpl_q   <= smpl_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    // Idle divider parks at 11111 so SCLK idles high without extra muxing.
    assign spi.SS_n = ~active_q;
    assign spi.SCLK = div_q[4];
    assign spi.MOSI = active_q & shft_q[15];
    assign done     = done_q;
    assign rd_data  = shft_q;

endmodule

// File: rtl/a2d_rr_reader.sv
// ADC128S round-robin reader: each nxt converts the next of LFT/RGHT/BATT using
// two SPI transactions (the ADC returns the channel requested one transaction earlier).
module a2d_rr_reader
    import a2d_pkg::*;
#(
    parameter logic [2:0] LFT_CH  = 3'd0,
    parameter logic [2:0] RGHT_CH = 3'd4,
    parameter logic [2:0] BATT_CH = 3'd5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    a2d_rr_reader_if.master spi,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        upd,
    output logic        busy
);

    state_t      state_q, state_d;
    rr_ptr_t     ptr_q,   ptr_d;
    logic [11:0] lft_q,   lft_d;
    logic [11:0] rght_q,  rght_d;
    logic [11:0] batt_q,  batt_d;

    logic        start;
    logic        done;
    logic [15:0] rd_data;
    logic [2:0]  ch;
    logic        unused_rd_hi;

    spi_mstr16 u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cmd     ({2'b00, ch, 11'h000}),
        .done    (done),
        .rd_data (rd_data),
        .spi     (spi)
    );

    assign unused_rd_hi = ^rd_data[15:12];

    always_comb begin
        case (ptr_q)
            RR_LFT:  ch = LFT_CH;
            RR_RGHT: ch = RGHT_CH;
            default: ch = BATT_CH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= RR_LFT;
            lft_q   <= '0;
            rght_q  <= '0;
            batt_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lft_q   <= lft_d;
            rght_q  <= rght_d;
            batt_q  <= batt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (nxt)  state_d = TX1;
            TX1:     if (done) state_d = GAP;
            GAP:               state_d = TX2;
            TX2:     if (done) state_d = UPD;
            default:           state_d = IDLE;
        endcase
    end

    always_comb begin
        start = (state_q == IDLE && nxt) || (state_q == GAP);
        upd   = (state_q == UPD);
        busy  = (state_q == TX1) || (state_q == GAP) || (state_q == TX2);
    end

    // Result lands on the TX2->UPD edge so it is already visible while upd is high.
    always_comb begin
        lft_d  = lft_q;
        rght_d = rght_q;
        batt_d = batt_q;
        ptr_d  = ptr_q;
        if (state_q == TX2 && done) begin
            case (ptr_q)
                RR_LFT:  lft_d  = rd_data[11:0];
                RR_RGHT: rght_d = rd_data[11:0];
                default: batt_d = rd_data[11:0];
            endcase
        end
        if (state_q == UPD) ptr_d = rr_next(ptr_q);
    end

    assign lft_ld  = lft_q;
    assign rght_ld = rght_q;
    assign batt    = batt_q;

endmodule

// File: tb/tb_a2d_rr_reader.sv
// Directed bench for a2d_rr_reader with a behavioural ADC128S on the SPI pins.
module tb_a2d_rr_reader;
    import a2d_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt = 1'b0;
    logic [11:0] lft_ld, rght_ld, batt;
    logic        upd, busy;

    a2d_rr_reader_if spi_bus ();

    a2d_rr_reader dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .nxt     (nxt),
        .spi     (spi_bus),
        .lft_ld  (lft_ld),
        .rght_ld (rght_ld),
        .batt    (batt),
        .upd     (upd),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ADC128S model set-points; upper nibble is non-zero so discarding [15:12] is visible.
    logic [11:0] lft_val  = 12'h3A5;
    logic [11:0] rght_val = 12'h5C2;
    logic [11:0] batt_val = 12'hC34;

    logic        ss_prev = 1'b1, sclk_prev = 1'b1;
    logic [15:0] tx_sr = '0, rx_sr = '0;
    logic [2:0]  prev_ch = 3'd0;
    int          nbits = 0, period_err = 0, sclk_edges = 0;
    time         last_rise = 0;
    logic [15:0] mosi_q[$];
    int          rise_q[$];

    function automatic logic [11:0] adc_val(input logic [2:0] c);
        case (c)
            3'd0:    adc_val = lft_val;
            3'd4:    adc_val = rght_val;
            3'd5:    adc_val = batt_val;
            default: adc_val = 12'hFFF;
        endcase
    endfunction

    always @(spi_bus.SS_n, spi_bus.SCLK) begin
        if (spi_bus.SCLK !== sclk_prev) sclk_edges++;
        if (ss_prev && !spi_bus.SS_n) begin
            tx_sr = {4'hA, adc_val(prev_ch)};
            spi_bus.MISO = 1'b0;
            nbits = 0;
        end else if (!ss_prev && spi_bus.SS_n) begin
            mosi_q.push_back(rx_sr);
            rise_q.push_back(nbits);
            if (nbits == 16) prev_ch = rx_sr[13:11];
        end else if (!spi_bus.SS_n && sclk_prev && !spi_bus.SCLK) begin
            spi_bus.MISO = tx_sr[15];
            tx_sr = tx_sr << 1;
        end else if (!spi_bus.SS_n && !sclk_prev && spi_bus.SCLK) begin
            rx_sr = {rx_sr[14:0], spi_bus.MOSI};
            nbits++;
            if (nbits > 1 && ($time - last_rise) != 320) period_err++;
            last_rise = $time;
        end
        ss_prev   = spi_bus.SS_n;
        sclk_prev = spi_bus.SCLK;
    end

    task automatic wait_upd(input string name, output int cyc);
        cyc = 0;
        while (!upd && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (!upd) begin
            n_fail++;
            $display("FAIL %s: upd timeout after %0d clks, expected pulse", name, cyc);
        end
    endtask

    // One full conversion from a single nxt pulse, checking latency and both command words.
    task automatic do_conv(input string name, input logic [15:0] exp_cmd);
        int cyc;
        mosi_q.delete();
        rise_q.delete();
        @(negedge clk);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        wait_upd(name, cyc);
        cyc++;
        n_checks++;
        if (cyc !== 1046) begin
            n_fail++;
            $display("FAIL %s latency: got %0d clks, expected 1046", name, cyc);
        end
        n_checks++;
        if (mosi_q.size() != 2 || mosi_q[0] !== exp_cmd || mosi_q[1] !== exp_cmd) begin
            n_fail++;
            $display("FAIL %s mosi: %0d words first %h, expected 2 x %h", name, mosi_q.size(),
                     (mosi_q.size() > 0) ? mosi_q[0] : 16'hxxxx, exp_cmd);
        end
        n_checks++;
        if (rise_q.size() != 2 || rise_q[0] != 16 || rise_q[1] != 16) begin
            n_fail++;
            $display("FAIL %s sclk rises: %0d windows first %0d, expected 2 x 16", name,
                     rise_q.size(), (rise_q.size() > 0) ? rise_q[0] : -1);
        end
    endtask

    task automatic test_reset();
        int e0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (spi_bus.SS_n !== 1'b1 || spi_bus.SCLK !== 1'b1 || spi_bus.MOSI !== 1'b0) begin
            n_fail++;
            $display("FAIL reset pins: SS_n=%b SCLK=%b MOSI=%b, expected 1 1 0",
                     spi_bus.SS_n, spi_bus.SCLK, spi_bus.MOSI);
        end
        n_checks++;
        if (lft_ld !== 12'h000 || rght_ld !== 12'h000 || batt !== 12'h000) begin
            n_fail++;
            $display("FAIL reset results: %h %h %h, expected 000 000 000", lft_ld, rght_ld, batt);
        end
        n_checks++;
        if (upd !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset status: upd=%b busy=%b, expected 0 0", upd, busy);
        end
        e0 = sclk_edges;
        repeat (100) @(negedge clk);
        n_checks++;
        if (sclk_edges != e0 || spi_bus.SS_n !== 1'b1) begin
            n_fail++;
            $display("FAIL idle sclk: %0d toggles SS_n=%b, expected 0 toggles SS_n=1",
                     sclk_edges - e0, spi_bus.SS_n);
        end
    endtask

    task automatic test_single();
        do_conv("single", 16'h0000);
        n_checks++;
        if (lft_ld !== 12'h3A5 || rght_ld !== 12'h000 || batt !== 12'h000) begin
            n_fail++;
            $display("FAIL single results: %h %h %h, expected 3a5 000 000", lft_ld, rght_ld, batt);
        end
    endtask

    task automatic test_round_robin();
        do_conv("rght", 16'h2000);
        n_checks++;
        if (lft_ld !== 12'h3A5 || rght_ld !== 12'h5C2 || batt !== 12'h000) begin
            n_fail++;
            $display("FAIL rght results: %h %h %h, expected 3a5 5c2 000", lft_ld, rght_ld, batt);
        end
        do_conv("batt", 16'h2800);
        n_checks++;
        if (lft_ld !== 12'h3A5 || rght_ld !== 12'h5C2 || batt !== 12'hC34) begin
            n_fail++;
            $display("FAIL batt results: %h %h %h, expected 3a5 5c2 c34", lft_ld, rght_ld, batt);
        end
        lft_val = 12'h0F0;
        do_conv("wrap", 16'h0000);
        n_checks++;
        if (lft_ld !== 12'h0F0 || rght_ld !== 12'h5C2 || batt !== 12'hC34) begin
            n_fail++;
            $display("FAIL wrap results: %h %h %h, expected 0f0 5c2 c34", lft_ld, rght_ld, batt);
        end
    endtask

    task automatic test_sclk();
        n_checks++;
        if (period_err != 0) begin
            n_fail++;
            $display("FAIL sclk period: %0d bad rise intervals, expected 0", period_err);
        end
    endtask

    task automatic test_nxt_busy();
        int n_upd = 0;
        rght_val = 12'h123;
        @(negedge clk);
        nxt = 1'b1;
        for (int i = 0; i < 1300; i++) begin
            @(negedge clk);
            nxt = (i < 1000 && (i % 97) == 5);
            if (upd) n_upd++;
        end
        nxt = 1'b0;
        n_checks++;
        if (n_upd != 1) begin
            n_fail++;
            $display("FAIL busy nxt: %0d upd pulses, expected 1", n_upd);
        end
        n_checks++;
        if (lft_ld !== 12'h0F0 || rght_ld !== 12'h123 || batt !== 12'hC34) begin
            n_fail++;
            $display("FAIL busy results: %h %h %h, expected 0f0 123 c34", lft_ld, rght_ld, batt);
        end
        n_checks++;
        if (busy !== 1'b0 || spi_bus.SS_n !== 1'b1) begin
            n_fail++;
            $display("FAIL busy idle: busy=%b SS_n=%b, expected 0 1", busy, spi_bus.SS_n);
        end
    endtask

    task automatic test_nxt_held();
        int cyc;
        batt_val = 12'h777;
        lft_val  = 12'h456;
        @(negedge clk);
        nxt = 1'b1;
        wait_upd("held batt", cyc);
        n_checks++;
        if (batt !== 12'h777) begin
            n_fail++;
            $display("FAIL held batt: got %h, expected 777", batt);
        end
        repeat (2) @(negedge clk);
        nxt = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || spi_bus.SS_n !== 1'b0) begin
            n_fail++;
            $display("FAIL held restart: busy=%b SS_n=%b, expected 1 0", busy, spi_bus.SS_n);
        end
        wait_upd("held lft", cyc);
        n_checks++;
        if (lft_ld !== 12'h456 || rght_ld !== 12'h123 || batt !== 12'h777) begin
            n_fail++;
            $display("FAIL held lft: %h %h %h, expected 456 123 777", lft_ld, rght_ld, batt);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        @(negedge clk);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        repeat (700) @(negedge clk);
        n_checks++;
        if (spi_bus.SS_n !== 1'b0) begin
            n_fail++;
            $display("FAIL abort setup: SS_n=%b, expected 0 mid-TX2", spi_bus.SS_n);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (spi_bus.SS_n !== 1'b1 || spi_bus.SCLK !== 1'b1 || busy !== 1'b0 || upd !== 1'b0) begin
            n_fail++;
            $display("FAIL abort pins: SS_n=%b SCLK=%b busy=%b upd=%b, expected 1 1 0 0",
                     spi_bus.SS_n, spi_bus.SCLK, busy, upd);
        end
        n_checks++;
        if (lft_ld !== 12'h000 || rght_ld !== 12'h000 || batt !== 12'h000) begin
            n_fail++;
            $display("FAIL abort results: %h %h %h, expected 000 000 000", lft_ld, rght_ld, batt);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        lft_val = 12'hABC;
        do_conv("after abort", 16'h0000);
        n_checks++;
        if (lft_ld !== 12'hABC || rght_ld !== 12'h000 || batt !== 12'h000) begin
            n_fail++;
            $display("FAIL after abort: %h %h %h, expected abc 000 000", lft_ld, rght_ld, batt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_sclk();
        test_nxt_busy();
        test_nxt_held();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
